wb_testing_slave: RTL and testbench
===================================

Name: wb_testing_slave

Overview:
- Wishbone B4 (classic + registered-feedback burst) slave containing a small bank of 32-bit read/write scratch registers.
- Sits behind the wb_switch interconnect as one of several slaves driven by a bus master (BFM in simulation).
- Used to verify interconnect decode, byte-lane writes, error signalling and burst handling.

Parameters:
- NUM_REGS, 8, number of 32-bit registers (power of two, 2..64).
- WINDOW_BITS, 12, address bits decoded locally; slave window is 2^WINDOW_BITS bytes.

Ports:
- wb_clk  in  1  bus clock; all logic on rising edge.
- wb_rst  in  1  asynchronous, active-high reset.
- wb_adr_i  in  32  byte address; the interconnect passes the full address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables; bit n covers bits [8n+7:8n].
- wb_we_i  in  1  1 = write, 0 = read.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe / beat valid.
- wb_cti_i  in  3  cycle type: 000 classic, 001 const burst, 010 incr burst, 111 end of burst.
- wb_bte_i  in  2  burst type; accepted but ignored (address taken from wb_adr_i every beat).
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  retry; tied to 0.

Behaviour:
- Reset (async assert, sync release): all registers 0; wb_dat_o 0; wb_ack_o 0; wb_err_o 0.
- req = wb_cyc_i & wb_stb_i.
- Index and decode:
  - idx = wb_adr_i[log2(NUM_REGS)+1:2].
  - Address is bad if wb_adr_i[1:0] != 0, or any bit in wb_adr_i[WINDOW_BITS-1 : log2(NUM_REGS)+2] is 1.
  - Bits at or above WINDOW_BITS are ignored.
- Beat acceptance, evaluated each cycle:
  - A beat is accepted when req=1 and either (a) wb_ack_o=0 and wb_err_o=0, or (b) wb_ack_o=1 and the previously accepted beat had cti 001 or 010.
- Response: registered, 1-cycle latency.
  - For an accepted good beat, wb_ack_o=1 in the next cycle.
  - For an accepted bad beat, wb_err_o=1 in the next cycle instead; ack and err are never both 1.
  - Otherwise both are 0 next cycle.
- Classic cycles (cti 000, 111, or any other value): the response is one cycle wide, then deasserts. Minimum spacing is therefore 2 cycles per transfer.
- Bursts: while accepted beats carry cti 001/010, ack stays high every cycle (one beat per cycle). The beat with cti 111 gets a single ack, then ack drops. An error always drops to 0 the following cycle and terminates any burst.
- Write (accepted good beat, wb_we_i=1):
  - reg[idx] byte n <= wb_dat_i byte n for each wb_sel_i[n]=1.
  - Register updates on the same edge that raises ack.
  - sel=0000 completes with ack but changes nothing.
- Read (accepted good beat, wb_we_i=0): wb_dat_o <= reg[idx], registered with ack; wb_sel_i is ignored on reads.
- wb_dat_o holds its last value when not acking; it is 0 after reset and is not updated on err.
- Master abort: if req drops while a response is outstanding, that response still completes (1 cycle). No new beat is accepted while req=0.
- Reset asserted mid-burst: outputs go to reset values immediately; the register contents are cleared.

Decomposition:
- Shared package wb_pkg: CTI constants (CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, EOB=3'b111), BTE constants, data/address width constants (32).
- Single sub-module natural: wb_slave_regbank (byte-enable write, combinational read mux, async reset). The top holds the decode and the ack/err/burst FSM (states IDLE, RESP, BURST).

Test Plan:
- Reset: assert wb_rst mid-idle -> ack/err/rty=0, dat_o=0; a read of 0x04 after release returns 0x00000000 with ack 1 cycle after stb.
- Classic write 0x08 = 0xDEADBEEF, sel=1111, then read 0x08 -> 0xDEADBEEF. Ack is a single-cycle pulse each time; err never asserts.
- Byte lanes: write 0x0C=0xFFFFFFFF, then write 0x0C=0x12345678 with sel=0101 -> read returns 0xFF34FF78.
- Bad address: read 0x02 (misaligned) and read 0x20 with NUM_REGS=8 -> wb_err_o=1 for one cycle, ack=0, and no register changes.
- Incrementing burst: 4 writes to 0x00..0x0C, cti 010,010,010,111, data 1..4 -> ack high for 4 consecutive cycles then low. A following 4-beat read burst returns 1,2,3,4 on consecutive cycles.
- Retry and aliasing: wb_rty_o stays 0 throughout all tests. Read of 0x1000+0x08 returns the same value as 0x08, since upper bits are ignored.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions for the scratch-register slave.
// Holds bus widths, CTI/BTE encodings, the response FSM state type and
// a helper that classifies a cycle type as a burst continuation.
package wb_pkg;

    localparam int unsigned WbDataW = 32;
    localparam int unsigned WbAdrW  = 32;
    localparam int unsigned WbSelW  = WbDataW / 8;

    // Cycle type identifiers
    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiConst   = 3'b001;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEob     = 3'b111;

    // Burst type extensions (accepted but not interpreted)
    localparam logic [1:0] BteLinear = 2'b00;
    localparam logic [1:0] BteWrap4  = 2'b01;
    localparam logic [1:0] BteWrap8  = 2'b10;
    localparam logic [1:0] BteWrap16 = 2'b11;

    // StIdle : no response on the bus
    // StResp : single-cycle ack or err on the bus, no beat may be accepted
    // StBurst: ack on the bus and the beat it answers asked to continue
    typedef enum logic [1:0] {
        StIdle,
        StResp,
        StBurst
    } wb_state_e;

    function automatic logic is_burst_cti(logic [2:0] cti);
        return (cti == CtiConst) || (cti == CtiIncr);
    endfunction

endpackage

// File: rtl/wb_testing_slave_if.sv
// Wishbone B4 bus bundle between one master and the scratch-register slave.
// Signal names follow the slave's point of view (_i into slave, _o out of it).
// Modports: master drives requests, slave drives responses.
interface wb_testing_slave_if;
    import wb_pkg::*;

    logic [WbAdrW-1:0]  wb_adr_i;
    logic [WbDataW-1:0] wb_dat_i;
    logic [WbSelW-1:0]  wb_sel_i;
    logic               wb_we_i;
    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic [2:0]         wb_cti_i;
    logic [1:0]         wb_bte_i;
    logic [WbDataW-1:0] wb_dat_o;
    logic               wb_ack_o;
    logic               wb_err_o;
    logic               wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

endinterface

// File: rtl/wb_slave_regbank.sv
// Bank of NUM_REGS 32-bit scratch registers with byte-enable writes.
// Ports:
//   clk_i    clock (rising edge)
//   rst_i    asynchronous active-high reset, clears every register
//   we_i     write strobe for the addressed register
//   idx_i    register index for both write and read
//   sel_i    byte enables for the write
//   wdata_i  write data
//   rdata_o  combinational read of regs[idx_i]
module wb_slave_regbank
    import wb_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IdxW     = $clog2(NUM_REGS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [IdxW-1:0]    idx_i,
    input  logic [WbSelW-1:0]  sel_i,
    input  logic [WbDataW-1:0] wdata_i,
    output logic [WbDataW-1:0] rdata_o
);

    logic [WbDataW-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < int'(WbSelW); b++) begin
                if (sel_i[b]) begin
                    regs_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = regs_q[idx_i];

endmodule

// File: rtl/wb_testing_slave.sv
// Wishbone B4 slave with a small bank of read/write scratch registers.
// Supports classic cycles and registered-feedback constant/incrementing
// bursts (one beat per cycle); bad addresses terminate with err.
// Ports:
//   wb_clk  bus clock (rising edge)
//   wb_rst  asynchronous active-high reset
//   wb      slave side of the Wishbone bundle
module wb_testing_slave
    import wb_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WINDOW_BITS = 12
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    wb_testing_slave_if.slave    wb
);

    localparam int unsigned IdxW = $clog2(NUM_REGS);

    wb_state_e          state_q, state_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [WbDataW-1:0] dat_q, dat_d;

    logic               req;
    logic               accept;
    logic               bad_adr;
    logic               reg_we;
    logic [IdxW-1:0]    idx;
    logic [WbDataW-1:0] rdata;

    assign req = wb.wb_cyc_i & wb.wb_stb_i;
    assign idx = wb.wb_adr_i[IdxW+1:2];

    // Address bits above the register index but inside the window must be
    // zero; bits at or above the window belong to the interconnect decode.
    assign bad_adr = (wb.wb_adr_i[1:0] != 2'b00) ||
                     (wb.wb_adr_i[WINDOW_BITS-1:IdxW+2] != '0);

    // A new beat fits when nothing is on the bus, or when the ack on the bus
    // answers a beat that asked to continue the burst.
    assign accept = req && ((state_q == StIdle) || (state_q == StBurst));

    always_comb begin
        state_d = StIdle;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        reg_we  = 1'b0;
        if (accept) begin
            if (bad_adr) begin
                err_d   = 1'b1;
                state_d = StResp;
            end else begin
                ack_d   = 1'b1;
                reg_we  = wb.wb_we_i;
                state_d = is_burst_cti(wb.wb_cti_i) ? StBurst : StResp;
                if (!wb.wb_we_i) begin
                    dat_d = rdata;
                end
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    wb_slave_regbank #(
        .NUM_REGS (NUM_REGS)
    ) u_regbank (
        .clk_i   (wb_clk),
        .rst_i   (wb_rst),
        .we_i    (reg_we),
        .idx_i   (idx),
        .sel_i   (wb.wb_sel_i),
        .wdata_i (wb.wb_dat_i),
        .rdata_o (rdata)
    );

    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_rty_o = 1'b0;

    // Burst type and out-of-window address bits are intentionally not used.
    logic unused_bits;
    assign unused_bits = ^{wb.wb_bte_i, wb.wb_adr_i[WbAdrW-1:WINDOW_BITS]};

endmodule

// File: tb/tb_wb_testing_slave.sv
// Scoreboard bench for wb_testing_slave: the driver queues the expected
// response of every beat it issues; a negedge monitor pops and checks each
// ack/err the slave presents.
module tb_wb_testing_slave;
    import wb_pkg::*;

    logic wb_clk = 1'b0;
    logic wb_rst;

    always #5 wb_clk = ~wb_clk;

    wb_testing_slave_if bus ();

    wb_testing_slave #(
        .NUM_REGS    (8),
        .WINDOW_BITS (12)
    ) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .wb     (bus.slave)
    );

    typedef struct {
        logic        is_err;
        logic        chk_dat;
        logic [31:0] dat;
        logic        b2b;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor
    int   cyc_cnt  = 0;
    int   last_cyc = -100;
    exp_t mon_e;

    always @(negedge wb_clk) begin
        cyc_cnt++;
        if (!wb_rst && (bus.wb_ack_o || bus.wb_err_o)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {30'd0, bus.wb_err_o, bus.wb_ack_o}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_err"}, {31'd0, bus.wb_err_o}, {31'd0, mon_e.is_err});
                chk({mon_e.name, "_ack"}, {31'd0, bus.wb_ack_o}, {31'd0, !mon_e.is_err});
                chk({mon_e.name, "_rty"}, {31'd0, bus.wb_rty_o}, 32'd0);
                if (mon_e.chk_dat) chk({mon_e.name, "_dat"}, bus.wb_dat_o, mon_e.dat);
                if (mon_e.b2b) chk({mon_e.name, "_spacing"}, cyc_cnt - last_cyc, 32'd1);
            end
            last_cyc = cyc_cnt;
        end
    end

    task automatic push(input string name, input logic is_err, input logic chk_dat,
                        input logic [31:0] dat, input logic b2b);
        exp_t e;
        e.name = name; e.is_err = is_err; e.chk_dat = chk_dat; e.dat = dat; e.b2b = b2b;
        exp_q.push_back(e);
    endtask

    task automatic beat(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, input logic [2:0] cti);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cti_i = cti;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(posedge wb_clk);
        #1;
    endtask

    task automatic release_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cti_i = CtiClassic;
        @(posedge wb_clk);
        #1;
    endtask

    // Classic single transfer; the response must be visible one cycle after stb.
    task automatic classic(input string name, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input logic is_err,
                           input logic [31:0] exp_dat);
        push(name, is_err, !we && !is_err, exp_dat, 1'b0);
        beat(adr, dat, sel, we, CtiClassic);
        chk({name, "_latency"}, {31'd0, bus.wb_ack_o | bus.wb_err_o}, 32'd1);
        release_bus();
    endtask

    initial begin
        wb_rst       = 1'b1;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cti_i = CtiClassic;
        bus.wb_bte_i = BteLinear;
        repeat (3) @(posedge wb_clk);
        #1;
        chk("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        chk("rst_err", {31'd0, bus.wb_err_o}, 32'd0);
        chk("rst_rty", {31'd0, bus.wb_rty_o}, 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        wb_rst = 1'b0;
        @(posedge wb_clk);
        #1;

        classic("rd_after_rst", 32'h04, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0000_0000);

        classic("wr_08", 32'h08, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0);
        classic("rd_08", 32'h08, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);

        classic("wr_0c_all", 32'h0C, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0);
        classic("wr_0c_lanes", 32'h0C, 32'h1234_5678, 4'b0101, 1'b1, 1'b0, 32'h0);
        classic("rd_0c", 32'h0C, 32'h0, 4'hF, 1'b0, 1'b0, 32'hFF34_FF78);

        // Incrementing write burst then read burst, one beat per cycle.
        for (int i = 0; i < 4; i++) push("bwr", 1'b0, 1'b0, 32'h0, i != 0);
        for (int i = 0; i < 4; i++)
            beat(32'(4 * i), 32'(i + 1), 4'hF, 1'b1, (i == 3) ? CtiEob : CtiIncr);
        release_bus();
        for (int i = 0; i < 4; i++) push("brd", 1'b0, 1'b1, 32'(i + 1), i != 0);
        for (int i = 0; i < 4; i++)
            beat(32'(4 * i), 32'h0, 4'hF, 1'b0, (i == 3) ? CtiEob : CtiIncr);
        release_bus();

        // Bad addresses: err only, no register change, dat_o holds.
        classic("wr_bad_20", 32'h20, 32'hAAAA_AAAA, 4'hF, 1'b1, 1'b1, 32'h0);
        chk("dat_hold_after_err", bus.wb_dat_o, 32'h0000_0004);
        classic("rd_bad_02", 32'h02, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);
        classic("rd_bad_20", 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);
        classic("wr_bad_0a", 32'h0A, 32'h5555_5555, 4'hF, 1'b1, 1'b1, 32'h0);
        classic("rd_00", 32'h00, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0000_0001);
        classic("rd_08_b", 32'h08, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0000_0003);
        classic("rd_alias", 32'h1008, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0000_0003);

        classic("wr_sel0", 32'h04, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 32'h0);
        classic("rd_04", 32'h04, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0000_0002);

        // Reset while a burst ack is on the bus.
        push("brst", 1'b0, 1'b0, 32'h0, 1'b0);
        beat(32'h10, 32'h9, 4'hF, 1'b1, CtiIncr);
        wb_rst = 1'b1;
        #1;
        chk("midburst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        chk("midburst_err", {31'd0, bus.wb_err_o}, 32'd0);
        chk("midburst_dat", bus.wb_dat_o, 32'd0);
        exp_q.delete();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
        @(posedge wb_clk);
        #1;
        classic("rd_08_cleared", 32'h08, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        classic("rd_00_cleared", 32'h00, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);

        repeat (3) @(posedge wb_clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
